// File: rtl/jpeg_rle_symbolizer.sv
// JPEG run-length symbolizer: turns zigzag-ordered coefficient rows
// (8 coefficients per beat, 8 beats per block) into (run, size, amplitude)
// symbols: DC differential, AC, ZRL and EOB.
// Optional feature macro: RLE_DC_RESTART_EN adds a dc_restart input that
// zeroes the DC predictor for the block whose beat 0 it accompanies.
module jpeg_rle_symbolizer #(
   parameter int COEF_W = 10,
   parameter int LANES  = 8,
   parameter int AMP_W  = COEF_W + 1
) (
   input  logic                    clk,
   input  logic                    reset,
`ifdef RLE_DC_RESTART_EN
   input  logic                    dc_restart,
`endif
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*COEF_W-1:0] in_data,
   output logic                    sym_valid,
   input  logic                    sym_ready,
   output logic [3:0]              sym_run,
   output logic [3:0]              sym_size,
   output logic [AMP_W-1:0]        sym_amp,
   output logic                    sym_is_dc,
   output logic                    sym_last
);

   typedef enum logic [1:0] {IDLE, SCAN, ZRL, EOB} state_t;

   state_t                    state, state_n;
   logic [LANES*COEF_W-1:0]   buf_data;
   logic                      buf_full;
   logic [2:0]                beat_cnt, beat_n;
   logic [2:0]                ptr, ptr_n;
   logic [6:0]                zrun, zrun_n;
   logic [COEF_W-1:0]         prev_dc, prev_dc_n;
   logic [COEF_W-1:0]         pred;
   logic                      accept, out_free, release_buf;
   logic                      emit, e_dc, e_last;
   logic [3:0]                e_run, e_size;
   logic [AMP_W-1:0]          e_amp;
   logic                      hit_found;
   logic [2:0]                hit_lane;
   logic [COEF_W-1:0]         hit_coef, dc_coef;
   logic [AMP_W-1:0]          ac_val, dc_diff;
   logic [6:0]                zr_sum;

   // Magnitude category: bit length of |v|, zero for v == 0.
   function automatic logic [3:0] calc_size(input logic [AMP_W-1:0] v);
      logic [AMP_W-1:0] mag;
      calc_size = '0;
      mag = v[AMP_W-1] ? -v : v;
      for (int i = 0; i < AMP_W; i++)
         if (mag[i]) calc_size = 4'(i + 1);
   endfunction

   // Amplitude bits: low sz bits of v, or of v-1 for negatives.
   function automatic logic [AMP_W-1:0] calc_amp(input logic [AMP_W-1:0] v,
                                                 input logic [3:0] sz);
      logic [AMP_W-1:0] t;
      t = v[AMP_W-1] ? (v - {{(AMP_W-1){1'b0}}, 1'b1}) : v;
      calc_amp = '0;
      for (int i = 0; i < AMP_W; i++)
         if (i < int'(sz)) calc_amp[i] = t[i];
   endfunction

   assign in_ready = ~buf_full;
   assign accept   = in_valid & ~buf_full;
   assign out_free = ~sym_valid | sym_ready;

   assign hit_coef = buf_data[hit_lane*COEF_W +: COEF_W];
   assign dc_coef  = buf_data[COEF_W-1:0];
   assign ac_val   = {{(AMP_W-COEF_W){hit_coef[COEF_W-1]}}, hit_coef};
   assign dc_diff  = {{(AMP_W-COEF_W){dc_coef[COEF_W-1]}}, dc_coef}
                   - {{(AMP_W-COEF_W){pred[COEF_W-1]}}, pred};
   assign zr_sum   = zrun + ({4'd0, hit_lane} - {4'd0, ptr});

`ifdef RLE_DC_RESTART_EN
   logic dc_zero_pred;

   // Remember the restart request that arrived with beat 0 of this block.
   always_ff @(posedge clk) begin
      if (!reset)
         dc_zero_pred <= 1'b0;
      else if (accept && beat_cnt == 3'd0)
         dc_zero_pred <= dc_restart;
   end

   assign pred = dc_zero_pred ? '0 : prev_dc;
`else
   assign pred = prev_dc;
`endif

   // Priority search for the lowest nonzero lane at or above the pointer.
   always_comb begin
      hit_found = 1'b0;
      hit_lane  = '0;
      for (int k = LANES - 1; k >= 0; k--) begin
         if (k >= int'(ptr) && buf_data[k*COEF_W +: COEF_W] != '0) begin
            hit_found = 1'b1;
            hit_lane  = 3'(k);
         end
      end
   end

   // Next-state and symbol selection; emitting states wait for a free output slot.
   always_comb begin
      state_n     = state;
      ptr_n       = ptr;
      zrun_n      = zrun;
      beat_n      = beat_cnt;
      prev_dc_n   = prev_dc;
      release_buf = 1'b0;
      emit        = 1'b0;
      e_run       = '0;
      e_size      = '0;
      e_amp       = '0;
      e_dc        = 1'b0;
      e_last      = 1'b0;
      case (state)
         IDLE: begin
            if (accept || buf_full) state_n = SCAN;
         end
         SCAN: begin
            if (out_free) begin
               if (beat_cnt == 3'd0 && ptr == 3'd0) begin
                  emit      = 1'b1;
                  e_dc      = 1'b1;
                  e_size    = calc_size(dc_diff);
                  e_amp     = calc_amp(dc_diff, e_size);
                  prev_dc_n = dc_coef;
                  ptr_n     = 3'd1;
                  zrun_n    = '0;
               end else if (!hit_found) begin
                  release_buf = 1'b1;
                  ptr_n       = '0;
                  beat_n      = beat_cnt + 3'd1;
                  if (beat_cnt == 3'd7) begin
                     zrun_n  = '0;
                     state_n = EOB;
                  end else begin
                     zrun_n  = zrun + (7'd8 - {4'd0, ptr});
                     state_n = IDLE;
                  end
               end else if (zr_sum >= 7'd16) begin
                  zrun_n  = zr_sum;
                  ptr_n   = hit_lane;
                  state_n = ZRL;
               end else begin
                  emit   = 1'b1;
                  e_run  = zr_sum[3:0];
                  e_size = calc_size(ac_val);
                  e_amp  = calc_amp(ac_val, e_size);
                  zrun_n = '0;
                  if (hit_lane == 3'd7) begin
                     e_last      = (beat_cnt == 3'd7);
                     release_buf = 1'b1;
                     ptr_n       = '0;
                     beat_n      = beat_cnt + 3'd1;
                     state_n     = IDLE;
                  end else begin
                     ptr_n = hit_lane + 3'd1;
                  end
               end
            end
         end
         ZRL: begin
            if (out_free) begin
               emit   = 1'b1;
               e_run  = 4'd15;
               zrun_n = zrun - 7'd16;
               if (zrun < 7'd32) state_n = SCAN;
            end
         end
         EOB: begin
            if (out_free) begin
               emit    = 1'b1;
               e_last  = 1'b1;
               state_n = (buf_full || accept) ? SCAN : IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State, beat buffer and output register updates.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         buf_data  <= '0;
         buf_full  <= 1'b0;
         beat_cnt  <= '0;
         ptr       <= '0;
         zrun      <= '0;
         prev_dc   <= '0;
         sym_valid <= 1'b0;
         sym_run   <= '0;
         sym_size  <= '0;
         sym_amp   <= '0;
         sym_is_dc <= 1'b0;
         sym_last  <= 1'b0;
      end else begin
         state    <= state_n;
         beat_cnt <= beat_n;
         ptr      <= ptr_n;
         zrun     <= zrun_n;
         prev_dc  <= prev_dc_n;
         if (accept) begin
            buf_data <= in_data;
            buf_full <= 1'b1;
         end else if (release_buf) begin
            buf_full <= 1'b0;
         end
         if (out_free) begin
            sym_valid <= emit;
            sym_run   <= e_run;
            sym_size  <= e_size;
            sym_amp   <= e_amp;
            sym_is_dc <= e_dc;
            sym_last  <= e_last;
         end
      end
   end

endmodule

// File: tb/tb_jpeg_rle_symbolizer.sv
// Directed testbench for jpeg_rle_symbolizer: feeds hand-built 8x8 blocks
// and compares the emitted symbol stream against hand-computed symbols.
module tb_jpeg_rle_symbolizer;

   localparam int COEF_W = 10;
   localparam int LANES  = 8;
   localparam int AMP_W  = COEF_W + 1;

   logic                    clk = 1'b0;
   logic                    reset = 1'b0;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic [LANES*COEF_W-1:0] in_data = '0;
   logic                    sym_valid;
   logic                    sym_ready = 1'b1;
   logic [3:0]              sym_run, sym_size;
   logic [AMP_W-1:0]        sym_amp;
   logic                    sym_is_dc, sym_last;
`ifdef RLE_DC_RESTART_EN
   logic                    dc_restart = 1'b0;
`endif

   logic [COEF_W-1:0] coef_mem [64];
   logic [20:0]       got_q [$];
   logic [20:0]       exp_q [$];
   int                checks = 0;
   int                errors = 0;
   int                ready_viol = 0;
   int                hold_viol = 0;
   int                lat;

   jpeg_rle_symbolizer #(.COEF_W(COEF_W), .LANES(LANES), .AMP_W(AMP_W)) dut (
      .clk       (clk),
      .reset     (reset),
`ifdef RLE_DC_RESTART_EN
      .dc_restart(dc_restart),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .sym_run   (sym_run),
      .sym_size  (sym_size),
      .sym_amp   (sym_amp),
      .sym_is_dc (sym_is_dc),
      .sym_last  (sym_last)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   function automatic logic [20:0] mkSym(int run, int size, int amp, bit dc, bit last);
      return {4'(run), 4'(size), 11'(amp), dc, last};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clearBlock();
      for (int i = 0; i < 64; i++) coef_mem[i] = '0;
   endtask

   task automatic checkSymbols(input string tag);
      checkOutput({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         checkOutput($sformatf("%s sym%0d", tag, i),
                     (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFFFFFF,
                     32'(exp_q[i]));
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput(tag, 32'({in_ready, sym_valid, sym_run, sym_size, sym_amp, sym_is_dc, sym_last}),
                  32'({1'b1, 22'd0}));
   endtask

   // Feed n_beats beats of coef_mem and collect accepted symbols until the
   // output has been quiet for a while (or stop right after the last accept).
   task automatic applyStimulus(input int n_beats, input bit toggle_ready,
                                input bit stop_after_feed, output int latency);
      int          beat = 0;
      int          budget = 0;
      int          acc_iter = -1;
      int          first_valid = -1;
      int          idle = 0;
      bit          last_acc = 1'b0;
      bit          prev_stalled = 1'b0;
      logic [20:0] prev_sym = '0;
      logic [20:0] cur;
      got_q.delete();
      while (budget < 3000) begin
         @(negedge clk);
         budget++;
         if (beat < n_beats) begin
            in_valid = 1'b1;
            for (int k = 0; k < LANES; k++)
               in_data[k*COEF_W +: COEF_W] = coef_mem[beat*LANES + k];
         end else begin
            in_valid = 1'b0;
         end
         sym_ready = toggle_ready ? budget[0] : 1'b1;
         if (stop_after_feed && beat == n_beats) break;
         cur = {sym_run, sym_size, sym_amp, sym_is_dc, sym_last};
         if (last_acc && in_ready) ready_viol++;
         if (prev_stalled && (!sym_valid || cur != prev_sym)) hold_viol++;
         if (sym_valid && first_valid < 0) first_valid = budget;
         if (sym_valid && sym_ready) got_q.push_back(cur);
         prev_stalled = sym_valid && !sym_ready;
         prev_sym     = cur;
         last_acc     = in_valid && in_ready;
         if (last_acc) begin
            if (beat == 0) acc_iter = budget;
            beat++;
         end
         if (beat == n_beats && !sym_valid) idle++;
         else idle = 0;
         if (idle > 40) break;
      end
      in_valid  = 1'b0;
      sym_ready = 1'b1;
      latency   = first_valid - acc_iter;
   endtask

   // Directed test sequence.
   initial begin
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkResetOutputs("reset outputs");
      reset = 1'b1;

      clearBlock();
      coef_mem[0] = 10'd5;
      exp_q.delete();
      exp_q.push_back(mkSym(0, 3, 5, 1, 0));
      exp_q.push_back(mkSym(0, 0, 0, 0, 1));
      applyStimulus(8, 1'b0, 1'b0, lat);
      checkSymbols("dc_only");
      checkOutput("dc latency", 32'(lat), 32'd2);

      exp_q.delete();
      exp_q.push_back(mkSym(0, 0, 0, 1, 0));
      exp_q.push_back(mkSym(0, 0, 0, 0, 1));
      applyStimulus(8, 1'b0, 1'b0, lat);
      checkSymbols("dc_zero_diff");

      coef_mem[1] = 10'h3FD;
      exp_q.delete();
      exp_q.push_back(mkSym(0, 0, 0, 1, 0));
      exp_q.push_back(mkSym(0, 2, 0, 0, 0));
      exp_q.push_back(mkSym(0, 0, 0, 0, 1));
      applyStimulus(8, 1'b0, 1'b0, lat);
      checkSymbols("neg_ac");

      clearBlock();
      coef_mem[0]  = 10'd5;
      coef_mem[34] = 10'd1;
      exp_q.delete();
      exp_q.push_back(mkSym(0, 0, 0, 1, 0));
      exp_q.push_back(mkSym(15, 0, 0, 0, 0));
      exp_q.push_back(mkSym(15, 0, 0, 0, 0));
      exp_q.push_back(mkSym(1, 1, 1, 0, 0));
      exp_q.push_back(mkSym(0, 0, 0, 0, 1));
      applyStimulus(8, 1'b0, 1'b0, lat);
      checkSymbols("zrl");

      clearBlock();
      coef_mem[0]  = 10'd5;
      coef_mem[63] = 10'h3FF;
      exp_q.delete();
      exp_q.push_back(mkSym(0, 0, 0, 1, 0));
      for (int i = 0; i < 3; i++) exp_q.push_back(mkSym(15, 0, 0, 0, 0));
      exp_q.push_back(mkSym(14, 1, 0, 0, 1));
      applyStimulus(8, 1'b0, 1'b0, lat);
      checkSymbols("last_coef");

      for (int i = 1; i < 64; i++) coef_mem[i] = 10'd1;
      coef_mem[0] = 10'h3FE;
      exp_q.delete();
      exp_q.push_back(mkSym(0, 3, 0, 1, 0));
      for (int i = 1; i < 63; i++) exp_q.push_back(mkSym(0, 1, 1, 0, 0));
      exp_q.push_back(mkSym(0, 1, 1, 0, 1));
      applyStimulus(8, 1'b1, 1'b0, lat);
      checkSymbols("dense_bp");

      coef_mem[0] = 10'd100;
      applyStimulus(5, 1'b0, 1'b1, lat);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkResetOutputs("mid-block reset");
      reset = 1'b1;

      clearBlock();
      coef_mem[0] = 10'd5;
      exp_q.delete();
      exp_q.push_back(mkSym(0, 3, 5, 1, 0));
      exp_q.push_back(mkSym(0, 0, 0, 0, 1));
      applyStimulus(8, 1'b0, 1'b0, lat);
      checkSymbols("after_reset");

      checkOutput("in_ready while full", 32'(ready_viol), 32'd0);
      checkOutput("stall hold", 32'(hold_viol), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
